// File: rtl/layer_serializer.sv
// Parallel-to-serial bridge between two fully-connected layers: captures a whole
// layer output vector and replays it one neuron per cycle, neuron 0 first.
// Optional pending-vector buffer: define LAYER_SERIALIZER_DBL_BUF_EN.
module layer_serializer #(
  parameter int NUM_NEURONS = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int IDX_WIDTH   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic                              out_last,
  output logic [IDX_WIDTH-1:0]              out_idx,
  output logic                              busy,
  output logic                              overflow,
  output logic                              dbg_state
);
  // Handshake: no ready on either side. in_valid is a one-cycle strobe that is
  // either accepted (idle / last beat / free pending slot) or dropped with
  // overflow set; out_valid beats must be consumed on the cycle they appear.

  localparam int VW = NUM_NEURONS * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  cnt, cnt_nxt;
  logic [VW-1:0]         hold, hold_nxt;
  logic                  ovf_nxt;
  logic                  valid_nxt;
  logic                  last_nxt;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] data_nxt;
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
  logic [VW-1:0]         pend, pend_nxt;
  logic                  pend_vld, pend_vld_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold      <= '0;
      overflow  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
      pend      <= '0;
      pend_vld  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      overflow  <= ovf_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
      pend      <= pend_nxt;
      pend_vld  <= pend_vld_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    ovf_nxt   = overflow;
    is_last   = (state == SEND) && (cnt == LAST_IDX);
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
    pend_nxt     = pend;
    pend_vld_nxt = pend_vld;
`endif
    if (state == IDLE || is_last) begin
      // A new stream may start here with no bubble after the last beat.
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
      if (pend_vld) begin
        hold_nxt     = pend;
        cnt_nxt      = '0;
        state_nxt    = SEND;
        pend_vld_nxt = in_valid;
        if (in_valid) pend_nxt = in_data;
      end else
`endif
      if (in_valid) begin
        hold_nxt  = in_data;
        cnt_nxt   = '0;
        state_nxt = SEND;
      end else begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    end else begin
      cnt_nxt = cnt + 1'b1;
      if (in_valid) begin
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
        if (!pend_vld) begin
          pend_nxt     = in_data;
          pend_vld_nxt = 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
`else
        ovf_nxt = 1'b1;
`endif
      end
    end
    valid_nxt = (state_nxt == SEND);
    last_nxt  = valid_nxt && (cnt_nxt == LAST_IDX);
    data_nxt  = valid_nxt ? hold_nxt[cnt_nxt*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // cnt is forced to 0 outside SEND, so it doubles as the registered index.
  assign out_idx   = cnt;
  assign busy      = (state == SEND);
  assign dbg_state = state;

endmodule

// File: tb/tb_layer_serializer.sv
// Self-checking bench for layer_serializer: a 4-neuron and a 1-neuron instance,
// directed scenarios followed by random traffic, compared against a beat-queue model.
module tb_layer_serializer;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int VW = N * DW;
  localparam int BW = 1 + 8 + DW;  // {last, idx, data}
`ifdef LAYER_SERIALIZER_DBL_BUF_EN
  localparam int CAP = N;  // beats that may still be queued behind the current one
`else
  localparam int CAP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, busy, overflow, dbg_state;
  logic [1:0]    out_idx;

  logic          in_valid1 = 1'b0;
  logic [DW-1:0] in_data1 = '0;
  logic [DW-1:0] out_data1;
  logic          out_valid1, out_last1, busy1, overflow1, dbg_state1;
  logic [0:0]    out_idx1;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp1_q[$];
  logic          ovf_exp = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  layer_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_idx(out_idx), .busy(busy), .overflow(overflow), .dbg_state(dbg_state)
  );

  layer_serializer #(.NUM_NEURONS(1), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
    .out_data(out_data1), .out_valid(out_valid1), .out_last(out_last1),
    .out_idx(out_idx1), .busy(busy1), .overflow(overflow1), .dbg_state(dbg_state1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [BW-1:0] b;
    if (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      check("n4_valid", 32'(out_valid), 32'd1);
      check("n4_data",  32'(out_data),  32'(b[DW-1:0]));
      check("n4_idx",   32'(out_idx),   32'(b[DW+7:DW]));
      check("n4_last",  32'(out_last),  32'(b[BW-1]));
      check("n4_busy",  32'(busy),      32'd1);
    end else begin
      check("n4_valid", 32'(out_valid), 32'd0);
      check("n4_data",  32'(out_data),  32'd0);
      check("n4_idx",   32'(out_idx),   32'd0);
      check("n4_last",  32'(out_last),  32'd0);
      check("n4_busy",  32'(busy),      32'd0);
    end
    check("n4_overflow", 32'(overflow), 32'(ovf_exp));
    if (exp1_q.size() > 0) begin
      b = exp1_q.pop_front();
      check("n1_valid", 32'(out_valid1), 32'd1);
      check("n1_data",  32'(out_data1),  32'(b[DW-1:0]));
      check("n1_idx",   32'(out_idx1),   32'd0);
      check("n1_last",  32'(out_last1),  32'd1);
    end else begin
      check("n1_valid", 32'(out_valid1), 32'd0);
      check("n1_data",  32'(out_data1),  32'd0);
      check("n1_last",  32'(out_last1),  32'd0);
    end
    check("n1_overflow", 32'(overflow1), 32'd0);
  endtask

  // One clock cycle: check what the DUTs show now, drive this cycle's inputs,
  // advance the model, then step past the next rising edge.
  task automatic cycle(input logic iv, input logic [VW-1:0] d, input logic r,
                       input logic iv1, input logic [DW-1:0] d1);
    check_outputs();
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    in_valid1 = iv1;
    in_data1  = d1;
    if (r) begin
      exp_q.delete();
      exp1_q.delete();
      ovf_exp = 1'b0;
    end else begin
      if (iv) begin
        if (exp_q.size() <= CAP) begin
          for (int k = 0; k < N; k++)
            exp_q.push_back({(k == N - 1), 8'(k), d[k*DW +: DW]});
        end else begin
          ovf_exp = 1'b1;
        end
      end
      if (iv1) exp1_q.push_back({1'b1, 8'd0, d1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [VW-1:0] vec4(input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                                         input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  initial begin
    logic [VW-1:0] va, vb, vc, vr;
    va = vec4(16'h0001, 16'h8000, 16'h7FFF, 16'h1234);
    vb = vec4(16'd5, 16'd6, 16'd7, 16'd8);
    vc = vec4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    repeat (2) @(posedge clk);
    #1;

    // single vector, then idle
    cycle(1'b1, va, 1'b0, 1'b0, '0);
    idle(6);
    // back-to-back on the last-element cycle
    cycle(1'b1, va, 1'b0, 1'b0, '0);
    idle(3);
    cycle(1'b1, vb, 1'b0, 1'b0, '0);
    idle(6);
    // second vector on a non-last element
    cycle(1'b1, va, 1'b0, 1'b0, '0);
    idle(1);
    cycle(1'b1, vb, 1'b0, 1'b0, '0);
    idle(9);
    // three vectors on consecutive cycles
    cycle(1'b1, va, 1'b0, 1'b0, '0);
    cycle(1'b1, vb, 1'b0, 1'b0, '0);
    cycle(1'b1, vc, 1'b0, 1'b0, '0);
    idle(10);
    // reset mid-stream, restart afterwards; N=1 instance gets 3,4,5 alongside
    cycle(1'b1, va, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd3);
    cycle(1'b0, '0, 1'b1, 1'b1, 16'd4);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd5);
    idle(1);
    cycle(1'b1, vb, 1'b0, 1'b1, 16'd3);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd4);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'd5);
    idle(6);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) vr[k*DW +: DW] = DW'($urandom);
      cycle($urandom_range(0, 3) == 0, vr, $urandom_range(0, 79) == 0,
            $urandom_range(0, 1) == 1, DW'($urandom));
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_serializer.md
Name: layer_serializer

Overview:
- Sits between two fully-connected layers.
- Captures the parallel outputs of all neurons of one layer in the cycle they become valid, then emits them one value per cycle as a serial stream.
- The stream drives the data input and input-valid of every neuron in the next layer.
- Element order matches the next layer's weight-memory read order: neuron 0 first.

Parameters:
- NUM_NEURONS, 30, number of neurons in the producing layer (= numWeight of the consuming layer); legal range >= 1.
- DATA_WIDTH, 16, width of one neuron output / next-layer input, two's complement.
- IDX_WIDTH, (NUM_NEURONS>1 ? $clog2(NUM_NEURONS) : 1), width of out_idx.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  one-cycle strobe: in_data holds a complete layer output vector.
- in_data  input  NUM_NEURONS*DATA_WIDTH  packed outputs; neuron k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_data  output  DATA_WIDTH  serial element; 0 when out_valid low.
- out_valid  output  1  out_data valid this cycle.
- out_last  output  1  high with element NUM_NEURONS-1 only.
- out_idx  output  IDX_WIDTH  index of the current element; 0 when out_valid low.
- busy  output  1  high while in SEND state.
- overflow  output  1  sticky: a vector was dropped.

Behaviour:
- Reset: state=IDLE, out_data=0, out_valid=0, out_last=0, out_idx=0, busy=0, overflow=0, internal counter=0.
- Reset mid-stream aborts the stream immediately: no further out_valid. The captured vector is discarded.
- States:
  - IDLE: out_valid=0. On in_valid, latch in_data into the holding register, counter=0, go to SEND.
  - SEND: each cycle emit element[counter] with out_valid=1, out_idx=counter, then counter+1.
  - When counter==NUM_NEURONS-1: assert out_last. Next state is IDLE, unless a new vector is accepted this cycle; then stay in SEND with counter=0.
- All outputs are registered.
- Latency and timing:
  - in_valid accepted at cycle T gives element 0 at cycle T+1.
  - Elements arrive on consecutive cycles with no gaps; element N-1 at T+N.
  - busy equals out_valid.
- Acceptance rule: in_valid is accepted when state==IDLE, or when in SEND and the current cycle emits the last element. This gives a back-to-back stream with zero bubble.
- Drop rule: in_valid in SEND on a non-last element leaves the current stream untouched. The new vector is dropped and overflow is set to 1, held until rst.
- The holding register changes only on acceptance. in_data may change freely after the accepting cycle.
- NUM_NEURONS=1: every element has out_last=1, out_idx=0. in_valid is accepted every cycle, so no overflow is possible.
- No backpressure: the consumer must accept one element per cycle.
- Neurons reset their accumulators on their own outvalid. The stream contains exactly NUM_NEURONS valid beats per vector; the consumer depends on this count.

Optional Feature:
- Macro: LAYER_SERIALIZER_DBL_BUF_EN.
- Defined:
  - Adds one pending-vector register with a pending flag.
  - in_valid during SEND on a non-last element with pending empty: store to pending, no overflow.
  - On the last element, if pending is set: move pending into the holding register, counter=0, clear pending, continue SEND with no bubble.
  - in_valid on a last-element cycle with pending set: the pending vector is streamed next, and the incoming one moves into pending.
  - Overflow is set only when in_valid arrives on a non-last element with pending already full; the incoming vector is dropped.
  - rst clears pending.
- Undefined: single buffer only; drop rule as above.

Test Plan:
- NUM_NEURONS=4, DATA_WIDTH=16; in_valid at T with elements {0x0001,0x8000,0x7FFF,0x1234} (neuron 0 first) -> out_valid T+1..T+4, out_data 0x0001,0x8000,0x7FFF,0x1234, out_idx 0..3, out_last only at T+4, busy low at T+5.
- Second in_valid at T+4 (last-element cycle) with {5,6,7,8} -> element 5 at T+5, continuous 8-beat stream, overflow=0.
- in_valid at T+2 (non-last) -> stream unchanged, overflow=1 from T+3 and held; without DBL_BUF, IDLE at T+5. With DBL_BUF, no overflow and the second vector follows at T+5..T+8.
- DBL_BUF: in_valid at T+1 and T+2 -> second stored in pending; third is dropped and overflow=1; the stream shows first vector then second only.
- rst at T+2 during stream -> out_valid=0, out_data=0, busy=0 from T+3; in_valid at T+5 restarts at element 0.
- NUM_NEURONS=1: in_valid on 3 consecutive cycles with values 3,4,5 -> out_data 3,4,5 on consecutive cycles, out_last=1 on each, overflow=0.
